event_collector: RTL

EVENT_COLLECTOR -- requirements
Module: event_collector

---
 rtl/event_collector_pkg.sv | 10 +
 rtl/event_collector_if.sv | 22 ++
 rtl/event_collector_rr_arbiter.sv | 27 ++
 rtl/event_collector.sv | 61 ++++++
 4 files changed

// File: rtl/event_collector_pkg.sv
// event_collector_pkg: shared event bus config opcodes and decode helper.
package event_collector_pkg;
  typedef enum logic [3:0] {
    OP_MASK    = 4'h0,
    OP_CLR_OVF = 4'h1
  } cfg_op_e;
  function automatic logic [3:0] cfg_op(logic [31:0] w);
    return w[31:28];
  endfunction
endpackage

// File: rtl/event_collector_if.sv
// event_collector_if: event inputs, config stream, event-number stream and overflow flags.
interface event_collector_if #(
  parameter int COUNT_BITS = 4,
  parameter int EVENT_COUNT = 1 << COUNT_BITS
);
  logic [EVENT_COUNT-1:0] evt_in;
  logic [31:0] s_cfg_data;
  logic s_cfg_valid;
  logic s_cfg_ready;
  logic [COUNT_BITS-1:0] m_evno_data;
  logic m_evno_valid;
  logic m_evno_ready;
  logic [EVENT_COUNT-1:0] overflow;
  modport master (
    output evt_in, s_cfg_data, s_cfg_valid, m_evno_ready,
    input s_cfg_ready, m_evno_data, m_evno_valid, overflow
  );
  modport slave (
    input evt_in, s_cfg_data, s_cfg_valid, m_evno_ready,
    output s_cfg_ready, m_evno_data, m_evno_valid, overflow
  );
endinterface

// File: rtl/event_collector_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after last_grant, wrapping.
module rr_arbiter #(
  parameter int COUNT_BITS = 4,
  parameter int EVENT_COUNT = 1 << COUNT_BITS
) (
  input  logic [EVENT_COUNT-1:0] req,
  input  logic [COUNT_BITS-1:0]  last_grant,
  output logic                   any,
  output logic [COUNT_BITS-1:0]  grant
);
  logic [COUNT_BITS:0] sum, idx;
  always_comb begin
    any = 1'b0;
    grant = '0;
    sum = '0;
    idx = '0;
    // Scan farthest-first so the nearest request after last_grant is assigned last.
    for (int k = EVENT_COUNT; k >= 1; k--) begin
      sum = {1'b0, last_grant} + (COUNT_BITS+1)'(k);
      idx = sum >= (COUNT_BITS+1)'(EVENT_COUNT) ? sum - (COUNT_BITS+1)'(EVENT_COUNT) : sum;
      if (req[idx[COUNT_BITS-1:0]]) begin
        any = 1'b1;
        grant = idx[COUNT_BITS-1:0];
      end
    end
  end
endmodule

// File: rtl/event_collector.sv
// event_collector: masks and coalesces per-source events, emits round-robin event numbers.
module event_collector
  import event_collector_pkg::*;
#(
  parameter int COUNT_BITS = 4,
  parameter int EVENT_COUNT = 1 << COUNT_BITS,
  parameter logic [EVENT_COUNT-1:0] MASK_RESET = '1
) (
  input logic clk,
  input logic rst,
  event_collector_if.slave bus
);
  logic [EVENT_COUNT-1:0] mask_q, mask_d, pending_q, pending_d, overflow_q, overflow_d;
  logic [EVENT_COUNT-1:0] grant_vec, evt_m, cfg_bits;
  logic [COUNT_BITS-1:0] evno_q, evno_d, last_q, last_d, grant_idx;
  logic valid_q, valid_d, any, load, mask_wr, ovf_clr;
  logic unused_cfg;
  assign unused_cfg = ^bus.s_cfg_data[27:EVENT_COUNT];
  rr_arbiter #(.COUNT_BITS(COUNT_BITS), .EVENT_COUNT(EVENT_COUNT)) u_arb (
    .req(pending_q),
    .last_grant(last_q),
    .any(any),
    .grant(grant_idx)
  );
  always_comb begin
    cfg_bits = bus.s_cfg_data[EVENT_COUNT-1:0];
    mask_wr = bus.s_cfg_valid && cfg_op(bus.s_cfg_data) == OP_MASK;
    ovf_clr = bus.s_cfg_valid && cfg_op(bus.s_cfg_data) == OP_CLR_OVF;
    load = !valid_q || bus.m_evno_ready;
    grant_vec = load && any ? EVENT_COUNT'(1) << grant_idx : '0;
    evt_m = bus.evt_in & mask_q;
    mask_d = mask_wr ? cfg_bits : mask_q;
    // A new event on a granted source re-arms it; on an ungranted pending source it overflows.
    pending_d = ((pending_q & ~grant_vec) | evt_m) & mask_d;
    overflow_d = (overflow_q & ~(ovf_clr ? cfg_bits : '0)) | (evt_m & pending_q & ~grant_vec);
    valid_d = load ? any : valid_q;
    evno_d = load && any ? grant_idx : evno_q;
    last_d = load && any ? grant_idx : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q <= MASK_RESET;
      pending_q <= '0;
      overflow_q <= '0;
      valid_q <= 1'b0;
      evno_q <= '0;
      last_q <= COUNT_BITS'(EVENT_COUNT - 1);
    end else begin
      mask_q <= mask_d;
      pending_q <= pending_d;
      overflow_q <= overflow_d;
      valid_q <= valid_d;
      evno_q <= evno_d;
      last_q <= last_d;
    end
  end
  assign bus.s_cfg_ready = 1'b1;
  assign bus.m_evno_data = evno_q;
  assign bus.m_evno_valid = valid_q;
  assign bus.overflow = overflow_q;
endmodule
